rob_retire: RTL

//  In-order reorder buffer and retire stage; the release end of the rename/free-pool protocol.

---
 rtl/rob_retire.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - in-order reorder buffer and retire stage
//
// Purpose: holds dispatched instructions in program order and records their
// completion. It retires the head entry once that entry is complete. On
// retire it sends the result to the register file and releases the
// superseded physical register back to the free pool.
//
// Optional feature: define ROB_FLUSH_EN to add the `flush` input. Flush
// discards every entry; reclaiming P-regs on a flush is done by rename.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   flush                       (ROB_FLUSH_EN only) discard all entries
//   alloc_valid / alloc_ready   dispatch handshake; ready = not full
//   alloc_has_rd/rd/pd/old_pd   destination info of the dispatched instruction
//   alloc_idx                   ROB index given to the dispatched instruction (tail)
//   cmpl_valid/idx/data         functional-unit completion
//   retire_valid/we/rd/pd/data  registered retire strobe and register-file write
//   free_valid / free_preg      registered release of old_pd to the free pool
//   count / empty               occupancy
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd,
    input  logic [PREG_W-1:0] alloc_old_pd,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_idx,
    input  logic [DATA_W-1:0] cmpl_data,
    output logic              retire_valid,
    output logic              retire_we,
    output logic [AREG_W-1:0] retire_rd,
    output logic [PREG_W-1:0] retire_pd,
    output logic [DATA_W-1:0] retire_data,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    localparam logic [IDX_W:0] COUNT_FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_complete;
    logic [DEPTH-1:0]  ent_has_rd;
    logic [AREG_W-1:0] ent_rd     [DEPTH];
    logic [PREG_W-1:0] ent_pd     [DEPTH];
    logic [PREG_W-1:0] ent_old_pd [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    logic alloc_fire;
    logic retire_fire;
    logic cmpl_hit;
    logic flush_req;

`ifdef ROB_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // No bypass when full: a slot freed by this edge's retire is only
    // offered to dispatch on the following cycle.
    assign alloc_ready = (count != COUNT_FULL);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_idx   = tail;
    assign empty       = (count == '0);

    // Completion is qualified by the pre-edge valid bit. A completion aimed
    // at the slot being allocated on the same edge is therefore dropped.
    assign cmpl_hit    = cmpl_valid && ent_valid[cmpl_idx];
    assign retire_fire = ent_valid[head] && ent_complete[head];

    // Control state and registered retire outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_complete <= '0;
            retire_valid <= 1'b0;
            retire_we    <= 1'b0;
            retire_rd    <= '0;
            retire_pd    <= '0;
            retire_data  <= '0;
            free_valid   <= 1'b0;
            free_preg    <= '0;
        end else if (flush_req) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_complete <= '0;
            retire_valid <= 1'b0;
            retire_we    <= 1'b0;
            free_valid   <= 1'b0;
        end else begin
            retire_valid <= retire_fire;
            retire_we    <= retire_fire && ent_has_rd[head];
            free_valid   <= retire_fire && ent_has_rd[head];

            if (cmpl_hit) begin
                ent_complete[cmpl_idx] <= 1'b1;
            end

            // The retire slot and the alloc slot cannot coincide: equal
            // pointers mean the ROB is either empty (nothing retires) or
            // full (nothing allocates).
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
                retire_rd       <= ent_rd[head];
                retire_pd       <= ent_pd[head];
                retire_data     <= ent_data[head];
                free_preg       <= ent_old_pd[head];
                head            <= head + 1'b1;
            end

            if (alloc_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_complete[tail] <= 1'b0;
                tail               <= tail + 1'b1;
            end

            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload. It needs no reset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_has_rd[tail] <= alloc_has_rd;
            ent_rd[tail]     <= alloc_rd;
            ent_pd[tail]     <= alloc_pd;
            ent_old_pd[tail] <= alloc_old_pd;
        end
        if (cmpl_hit) begin
            ent_data[cmpl_idx] <= cmpl_data;
        end
    end

endmodule
